// File: rtl/gpio_uart_tx.sv
// gpio_uart_tx: queues GPIO byte stores in a FIFO and sends each byte as an 8N1 UART frame.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | line high, waiting for a queued byte
// S_START | start bit (low) for CLKS_PER_BIT cycles
// S_DATA  | 8 data bits, LSB first, each held for CLKS_PER_BIT cycles
// S_STOP  | stop bit (high); pops the next byte straight into S_START
module gpio_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  gpio_data,
  input  logic                        gpio_en,
  output logic                        tx,
  output logic                        busy,
  output logic                        fifo_full,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q;

  state_e        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  logic push, pop, full, empty, baud_last;

  // Full is judged on the registered count, so a push against a full FIFO
  // is dropped even when a pop happens on the same edge.
  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign push      = gpio_en && !full;
  assign count_d   = count_q + CW'(push) - CW'(pop);
  assign baud_last = (baud_q == BAUD_LAST);

  // FIFO storage; contents need no reset since count/pointers gate every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= gpio_data;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      if (gpio_en && full) overflow_q <= 1'b1;
    end
  end

  // Transmitter state, counters, shift register and registered line output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state logic, pop request and next line level (derived from next state).
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    tx_d    = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          bit_d  = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    unique case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx         = tx_q;
  assign busy       = (state_q != S_IDLE) || !empty;
  assign fifo_full  = full;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_gpio_uart_tx.sv
// Bench for gpio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=16.
module tb_gpio_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;

  logic       clk;
  logic       reset;
  logic [7:0] gpio_data;
  logic       gpio_en;
  logic       tx;
  logic       busy;
  logic       fifo_full;
  logic [4:0] fifo_count;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;   // line levels in time order, bit 9 first
  } vec_t;

  vec_t vecs [6];

  gpio_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .gpio_data (gpio_data),
    .gpio_en   (gpio_en),
    .tx        (tx),
    .busy      (busy),
    .fifo_full (fifo_full),
    .fifo_count(fifo_count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [9:0] frame_pat(input logic [7:0] b);
    logic [9:0] p;
    p[9] = 1'b0;
    for (int i = 0; i < 8; i++) p[8-i] = b[i];
    p[0] = 1'b1;
    return p;
  endfunction

  // Samples 10*CPB consecutive cycles, starting with the cycle after the next edge.
  task automatic check_frame(input logic [9:0] p, input string name);
    int bad;
    logic [9:0] got;
    bad = 0;
    got = '0;
    for (int j = 0; j < 10; j++) begin
      for (int c = 0; c < CPB; c++) begin
        step();
        if (tx !== p[9-j]) bad++;
        if (c == CPB / 2) got[9-j] = tx;
      end
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s: line %b (%0d bad cycles), expected %b", name, got, bad, p);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad_hi;

    // A5 and 3C are the hand-worked cases; the rest are edge patterns.
    vecs[0] = '{8'hA5, 10'b0101001011};
    vecs[1] = '{8'h00, 10'b0000000001};
    vecs[2] = '{8'hFF, 10'b0111111111};
    vecs[3] = '{8'h3C, 10'b0001111001};
    vecs[4] = '{8'h01, 10'b0100000001};
    vecs[5] = '{8'h80, 10'b0000000011};

    // Reset with a write strobe active: nothing may be enqueued.
    reset     = 1'b1;
    gpio_en   = 1'b1;
    gpio_data = 8'hAB;
    for (int r = 0; r < 2; r++) begin
      step();
      check("rst_tx",       32'(tx),         32'd1);
      check("rst_busy",     32'(busy),       32'd0);
      check("rst_count",    32'(fifo_count), 32'd0);
      check("rst_full",     32'(fifo_full),  32'd0);
      check("rst_overflow", 32'(overflow),   32'd0);
    end
    reset   = 1'b0;
    gpio_en = 1'b0;
    step();
    check("post_rst_count", 32'(fifo_count), 32'd0);
    check("post_rst_busy",  32'(busy),       32'd0);
    check("post_rst_tx",    32'(tx),         32'd1);

    // Single-byte frames from the vector table.
    for (int i = 0; i < 6; i++) begin
      gpio_data = vecs[i].data;
      gpio_en   = 1'b1;
      step();
      gpio_en = 1'b0;
      check($sformatf("v%0d_count_after_push", i), 32'(fifo_count), 32'd1);
      check($sformatf("v%0d_busy_after_push", i),  32'(busy),       32'd1);
      check($sformatf("v%0d_tx_after_push", i),    32'(tx),         32'd1);
      check_frame(vecs[i].line, $sformatf("v%0d_frame_%02h", i, vecs[i].data));
      check($sformatf("v%0d_busy_in_stop", i), 32'(busy), 32'd1);
      step();
      check($sformatf("v%0d_busy_end", i),  32'(busy),       32'd0);
      check($sformatf("v%0d_count_end", i), 32'(fifo_count), 32'd0);
      check($sformatf("v%0d_tx_end", i),    32'(tx),         32'd1);
      step();
      step();
    end

    // Back-to-back pushes give contiguous frames.
    gpio_data = 8'h00;
    gpio_en   = 1'b1;
    step();
    fork
      begin
        gpio_data = 8'hFF;
        step();
        gpio_data = 8'h3C;
        step();
        gpio_en = 1'b0;
      end
      begin
        check_frame(frame_pat(8'h00), "b2b_frame0");
        check_frame(frame_pat(8'hFF), "b2b_frame1");
        check_frame(frame_pat(8'h3C), "b2b_frame2");
      end
    join
    step();
    check("b2b_busy_end", 32'(busy), 32'd0);
    step();

    // Overflow: 18 consecutive pushes, the 18th is dropped.
    gpio_data = 8'h00;
    gpio_en   = 1'b1;
    step();
    fork
      begin
        for (int i = 1; i < 18; i++) begin
          gpio_data = 8'(i);
          gpio_en   = 1'b1;
          step();
          if (i == 1) check("ovf_count_push_pop", 32'(fifo_count), 32'd1);
          if (i == 16) begin
            check("ovf_count_16",  32'(fifo_count), 32'd16);
            check("ovf_full_16",   32'(fifo_full),  32'd1);
            check("ovf_flag_pre",  32'(overflow),   32'd0);
          end
          if (i == 17) begin
            check("ovf_count_drop", 32'(fifo_count), 32'd16);
            check("ovf_full_drop",  32'(fifo_full),  32'd1);
            check("ovf_flag_set",   32'(overflow),   32'd1);
          end
        end
        gpio_en = 1'b0;
      end
      begin
        for (int k = 0; k < 17; k++) begin
          check_frame(frame_pat(8'(k)), $sformatf("ovf_frame_%02h", k));
        end
      end
    join
    step();
    check("ovf_busy_drained",  32'(busy),       32'd0);
    check("ovf_count_drained", 32'(fifo_count), 32'd0);
    check("ovf_full_drained",  32'(fifo_full),  32'd0);
    check("ovf_flag_sticky",   32'(overflow),   32'd1);
    step();

    // Reset during data bit 3 of the first of three queued frames.
    gpio_en = 1'b1;
    gpio_data = 8'h11;
    step();
    gpio_data = 8'h22;
    step();
    gpio_data = 8'h33;
    step();
    gpio_en = 1'b0;
    check("midrst_count_queued", 32'(fifo_count), 32'd2);
    for (int i = 0; i < 15; i++) step();
    check("midrst_tx_bit3", 32'(tx), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_tx",       32'(tx),         32'd1);
    check("midrst_count",    32'(fifo_count), 32'd0);
    check("midrst_busy",     32'(busy),       32'd0);
    check("midrst_overflow", 32'(overflow),   32'd0);
    bad_hi = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (tx !== 1'b1 || busy !== 1'b0) bad_hi++;
    end
    check("midrst_line_quiet", 32'(bad_hi), 32'd0);

    // Push on the same edge as a STOP->START pop with one byte queued.
    gpio_data = 8'h5A;
    gpio_en   = 1'b1;
    step();
    fork
      begin
        gpio_data = 8'hC3;
        step();
        gpio_en = 1'b0;
        check("pp_count_queued", 32'(fifo_count), 32'd1);
        for (int i = 0; i < 39; i++) step();
        check("pp_count_before", 32'(fifo_count), 32'd1);
        gpio_data = 8'h96;
        gpio_en   = 1'b1;
        step();
        gpio_en = 1'b0;
        check("pp_count_across_pop", 32'(fifo_count), 32'd1);
      end
      begin
        check_frame(frame_pat(8'h5A), "pp_frame0");
        check_frame(frame_pat(8'hC3), "pp_frame1");
        check_frame(frame_pat(8'h96), "pp_frame2");
      end
    join
    step();
    check("pp_busy_end",  32'(busy),       32'd0);
    check("pp_count_end", 32'(fifo_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_uart_tx.md
# gpio_uart_tx

Serial transmitter for the CPU's 8-bit GPIO port. It sits directly downstream of the memory controller. Every GPIO store (`gpio_data` qualified by `gpio_en`) is queued in a small FIFO and sent out as an 8N1 UART frame on `tx`. The CPU can emit bytes back-to-back without stalling, and a sticky flag reports any byte lost to FIFO overflow.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200). Must be ≥ 2.
- `FIFO_DEPTH`, default 16: number of byte entries. Must be a power of two, ≥ 2.
- `clk`, in, 1: single system clock. All logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `gpio_data`, in, 8: byte from the memory controller's GPIO output.
- `gpio_en`, in, 1: write strobe. Each cycle it is high is one byte to enqueue.
- `tx`, out, 1: UART serial line. Idle level is high.
- `busy`, out, 1: high while a frame is in progress or the FIFO is non-empty.
- `fifo_full`, out, 1: FIFO holds `FIFO_DEPTH` entries.
- `fifo_count`, out, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `overflow`, out, 1: sticky. Set when a byte is dropped; cleared only by `reset`.

## Operation
- **FIFO:** circular buffer with wrapping read and write pointers and a registered count.
  - Push on each edge where `gpio_en`=1 and `fifo_full`=0.
  - Push while `fifo_full`=1: the byte is discarded and `overflow` is set. This holds even if a pop occurs on the same edge, because the full test uses the registered count.
  - Push and pop on the same edge leave the count unchanged.
- **FSM states:** IDLE, START, DATA, STOP.
  - A bit counter counts 0..7.
  - A baud counter counts 0..CLKS_PER_BIT-1 and resets on every state or bit change.
- **IDLE:**
  - `tx`=1.
  - If the FIFO is non-empty: pop the head byte into the shift register, go to START.
- **START:**
  - `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- **DATA:**
  - `tx` = shift register bit 0, sent LSB first.
  - Every CLKS_PER_BIT cycles, shift right and increment the bit index.
  - After bit 7, go to STOP.
- **STOP:**
  - `tx`=1 for CLKS_PER_BIT cycles.
  - At the end, if the FIFO is non-empty, pop and go directly to START with no idle cycle. Otherwise go to IDLE.
- **Frame length:** exactly 10·CLKS_PER_BIT cycles.
- **`busy`:** (state≠IDLE) OR (`fifo_count`≠0).
- **`tx`:** registered, so there is no combinational glitch path.

## Timing
- **Reset values:** `tx`=1, `busy`=0, `fifo_full`=0, `fifo_count`=0, `overflow`=0, FSM=IDLE, FIFO pointers and counters at 0.
- **Reset mid-frame:** the frame is aborted. `tx` is high from the edge where `reset` is sampled, and all queued bytes are discarded.
- **Latency from push to start bit:**
  - Push at edge N into an empty FIFO with FSM idle.
  - `fifo_count`=1 after edge N.
  - Pop at edge N+1, with `tx`=0 from edge N+1.
  - `fifo_count` returns to 0 after edge N+1.
- **Frame timing** (frame starting at edge S):
  - Data bit k occupies edges S+(k+1)·CLKS_PER_BIT through S+(k+2)·CLKS_PER_BIT−1.
  - Stop bit ends at S+10·CLKS_PER_BIT, which is the next pop or return to IDLE.
- **`overflow`:** set at the edge of the dropped push and visible in the following cycle.

## Test plan
- **Reset values:** assert `reset` for 2 cycles, with `gpio_en` also high -> `tx`=1, `busy`=0, `fifo_count`=0, `fifo_full`=0, `overflow`=0. Nothing is enqueued.
- **Single byte** (CLKS_PER_BIT=4): push 0xA5 at edge N -> `tx` falls at N+1. Line sequence is 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles. `busy` falls at N+41.
- **Back-to-back bytes:** push 0x00, 0xFF, 0x3C on consecutive edges -> three contiguous 40-cycle frames with no idle high cycle between a stop bit and the next start bit. Bits decode to the pushed values.
- **Overflow:** push 18 bytes (0x00..0x11) on consecutive edges from an empty FIFO.
  - `fifo_count` reaches 16 and `fifo_full`=1.
  - The 18th byte is dropped and `overflow`=1.
  - 17 frames carrying 0x00..0x10 are transmitted.
  - `overflow` stays 1 after the FIFO drains.
- **Reset mid-frame:** push 3 bytes, then assert `reset` during data bit 3 of the first frame -> `tx`=1 and `fifo_count`=0 from that edge. No further frames; line stays high for 100 cycles.
- **Push during pop edge:** push a byte on the same edge the STOP→START pop occurs, with 1 byte queued -> `fifo_count` unchanged at 1 across that edge. Both bytes transmitted in order.
